// File: rtl/parity.sv
// Three-input parity generator: combinational parity and ones count, plus a
// registered parity copy and a clearable running-parity accumulator.
module parity #(
    parameter bit ODD = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       a,
    input  logic       b,
    input  logic       c,
    input  logic       acc_en,
    input  logic       acc_clr,
    output logic       p,
    output logic [1:0] ones,
    output logic       p_q,
    output logic       p_acc
);

    logic p_d;
    logic p_acc_d;
    logic p_acc_q;

    always_comb begin
        p       = a ^ b ^ c ^ ODD;
        ones    = {1'b0, a} + {1'b0, b} + {1'b0, c};
        p_d     = p;
        p_acc_d = p_acc_q;
        // Clear takes priority over accumulate when both are asserted.
        if (acc_clr) begin
            p_acc_d = 1'b0;
        end else if (acc_en) begin
            p_acc_d = p_acc_q ^ p;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_q     <= 1'b0;
            p_acc_q <= 1'b0;
        end else begin
            p_q     <= p_d;
            p_acc_q <= p_acc_d;
        end
    end

    assign p_acc = p_acc_q;

endmodule

// File: tb/tb_parity.sv
// Self-checking bench for parity: table sweep, directed timing sequences and
// randomized cycles against a counting reference model, for both parity senses.
module tb_parity;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       a = 1'b0, b = 1'b0, c = 1'b0;
    logic       acc_en = 1'b0, acc_clr = 1'b0;
    logic       p0, pq0, pacc0;
    logic [1:0] ones0;
    logic       p1, pq1, pacc1;
    logic [1:0] ones1;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    parity #(.ODD(1'b0)) dut0 (
        .clk(clk), .rst(rst), .a(a), .b(b), .c(c),
        .acc_en(acc_en), .acc_clr(acc_clr),
        .p(p0), .ones(ones0), .p_q(pq0), .p_acc(pacc0)
    );

    parity #(.ODD(1'b1)) dut1 (
        .clk(clk), .rst(rst), .a(a), .b(b), .c(c),
        .acc_en(acc_en), .acc_clr(acc_clr),
        .p(p1), .ones(ones1), .p_q(pq1), .p_acc(pacc1)
    );

    typedef struct {
        logic [2:0] abc;
        logic       exp_p0;
        logic [1:0] exp_ones;
        logic       exp_p1;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int cnt0, cnt1, n, rst_now;

        vecs[0] = '{3'b000, 1'b0, 2'd0, 1'b1};
        vecs[1] = '{3'b001, 1'b1, 2'd1, 1'b0};
        vecs[2] = '{3'b010, 1'b1, 2'd1, 1'b0};
        vecs[3] = '{3'b011, 1'b0, 2'd2, 1'b1};
        vecs[4] = '{3'b100, 1'b1, 2'd1, 1'b0};
        vecs[5] = '{3'b101, 1'b0, 2'd2, 1'b1};
        vecs[6] = '{3'b110, 1'b0, 2'd2, 1'b1};
        vecs[7] = '{3'b111, 1'b1, 2'd3, 1'b0};

        // Reset state
        #2;
        check("reset_pq0", pq0, 0);
        check("reset_pacc0", pacc0, 0);
        check("reset_pq1", pq1, 0);
        check("reset_pacc1", pacc1, 0);
        @(negedge clk);
        rst = 1'b0;

        // Exhaustive sweep, both senses
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            {a, b, c} = vecs[i].abc;
            #1;
            check("sweep_p_even", p0, vecs[i].exp_p0);
            check("sweep_ones", ones0, vecs[i].exp_ones);
            check("sweep_ones_odd", ones1, vecs[i].exp_ones);
            check("sweep_p_odd", p1, vecs[i].exp_p1);
            after_edge();
            check("sweep_pq_even", pq0, vecs[i].exp_p0);
            check("sweep_pq_odd", pq1, vecs[i].exp_p1);
            check("sweep_pacc_idle", pacc0, 0);
        end

        // Registered output latency
        @(negedge clk);
        {a, b, c} = 3'b011;
        after_edge();
        check("reg_pq_011", pq0, 0);
        @(negedge clk);
        {a, b, c} = 3'b111;
        #1;
        check("reg_p_immediate", p0, 1);
        check("reg_pq_before_edge", pq0, 0);
        after_edge();
        check("reg_pq_after_edge", pq0, 1);

        // Accumulator from reset
        @(negedge clk);
        rst = 1'b1;
        #1;
        rst = 1'b0;
        acc_en = 1'b1;
        {a, b, c} = 3'b001;
        after_edge();
        check("acc0_step1", pacc0, 1);
        check("acc1_step1", pacc1, 0);
        @(negedge clk);
        {a, b, c} = 3'b011;
        after_edge();
        check("acc0_step2", pacc0, 1);
        check("acc1_step2", pacc1, 1);
        @(negedge clk);
        {a, b, c} = 3'b111;
        after_edge();
        check("acc0_step3", pacc0, 0);
        check("acc1_step3", pacc1, 1);
        @(negedge clk);
        {a, b, c} = 3'b001;
        acc_clr = 1'b1;
        after_edge();
        check("acc0_clr_wins", pacc0, 0);
        check("acc1_clr_wins", pacc1, 0);
        acc_clr = 1'b0;

        // Asynchronous reset mid-accumulation
        @(negedge clk);
        {a, b, c} = 3'b001;
        acc_en = 1'b1;
        after_edge();
        check("pre_rst_pacc", pacc0, 1);
        check("pre_rst_pq", pq0, 1);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_pq", pq0, 0);
        check("async_rst_pacc", pacc0, 0);
        {a, b, c} = 3'b111;
        for (int k = 0; k < 3; k++) begin
            after_edge();
            check("rst_hold_pq", pq0, 0);
            check("rst_hold_pacc", pacc0, 0);
            check("rst_hold_pq_odd", pq1, 0);
        end

        // Reset release
        @(negedge clk);
        {a, b, c} = 3'b100;
        acc_en = 1'b1;
        rst = 1'b0;
        after_edge();
        check("release_pq", pq0, 1);
        check("release_pacc", pacc0, 1);

        // Randomized cycles against a counting model
        cnt0 = pacc0 ? 1 : 0;
        cnt1 = 0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        rst = 1'b0;
        cnt0 = 0;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            a       = 1'($urandom_range(0, 1));
            b       = 1'($urandom_range(0, 1));
            c       = 1'($urandom_range(0, 1));
            acc_en  = ($urandom_range(0, 3) != 0);
            acc_clr = ($urandom_range(0, 9) == 0);
            rst_now = ($urandom_range(0, 24) == 0) ? 1 : 0;
            n = int'(a) + int'(b) + int'(c);
            #2;
            if (rst_now != 0) rst = 1'b1;
            #1;
            check("rnd_p_even", p0, n % 2);
            check("rnd_p_odd", p1, 1 - (n % 2));
            check("rnd_ones", ones0, n);
            if (rst_now != 0) begin
                check("rnd_async_pq", pq0, 0);
                check("rnd_async_pacc", pacc1, 0);
                cnt0 = 0;
                cnt1 = 0;
            end
            after_edge();
            if (rst_now != 0) begin
                check("rnd_rst_pq", pq1, 0);
                check("rnd_rst_pacc", pacc0, 0);
                rst = 1'b0;
            end else begin
                if (acc_clr) begin
                    cnt0 = 0;
                    cnt1 = 0;
                end else if (acc_en) begin
                    cnt0 += n % 2;
                    cnt1 += 1 - (n % 2);
                end
                check("rnd_pq_even", pq0, n % 2);
                check("rnd_pq_odd", pq1, 1 - (n % 2));
                check("rnd_pacc_even", pacc0, cnt0 % 2);
                check("rnd_pacc_odd", pacc1, cnt1 % 2);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
